// File: rtl/multicycle_control_fsm_pkg.sv
// multicycle_control_fsm_pkg: opcode, datapath-select and state encodings for the multi-cycle MIPS sequencer.
package multicycle_control_fsm_pkg;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_BRANCH = 4'd11;
  localparam logic [3:0] S_JUMP   = 4'd12;
  localparam logic [3:0] S_ERROR  = 4'd13;
  function automatic logic [3:0] decode_next(input logic [5:0] op);
    return op == OP_R ? S_EXEC :
           (op == OP_LW || op == OP_SW) ? S_MEMADR :
           op == OP_BEQ ? S_BRANCH :
           op == OP_ADDI ? S_ADDIEX :
           op == OP_J ? S_JUMP : S_ERROR;
  endfunction
endpackage

// File: rtl/multicycle_control_fsm_retire_counter.sv
// multicycle_control_fsm_retire_counter: wrapping count of retired instructions.
module multicycle_control_fsm_retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_d, count_q;
  assign count_d = count_q + CNT_W'(inc);
  assign count = count_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore sequencer for the multi-cycle MIPS datapath with
// memory handshake, retired-instruction counter and sticky illegal-opcode flag.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);
  logic [3:0] state_d, state_q;
  logic [5:0] op_d, op_q;
  logic       illegal_d, illegal_q;
  logic       fin;
  always_comb begin
    state_d = state_q;
    fin = 1'b0;
    case (state_q)
      S_IDLE:   state_d = run ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = decode_next(opcode);
      S_MEMADR: state_d = op_q == OP_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  fin = mem_ready;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: fin = 1'b1;
      default:  state_d = S_ERROR;
    endcase
    if (fin) state_d = run ? S_FETCH : S_IDLE;
  end
  assign op_d = state_q == S_DECODE ? opcode : op_q;
  assign illegal_d = illegal_q | (state_d == S_ERROR);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      illegal_q <= illegal_d;
    end
  // FETCH loads IR and PC only in the cycle memory actually returns the word
  assign pc_write      = (state_q == S_FETCH && mem_ready) || state_q == S_JUMP;
  assign ir_write      = state_q == S_FETCH && mem_ready;
  assign pc_write_cond = state_q == S_BRANCH;
  assign i_or_d        = state_q == S_MEMRD || state_q == S_MEMWR;
  assign mem_read      = state_q == S_FETCH || state_q == S_MEMRD;
  assign mem_write     = state_q == S_MEMWR;
  assign mem_to_reg    = state_q == S_MEMWB;
  assign reg_dst       = state_q == S_ALUWB;
  assign reg_write     = state_q == S_MEMWB || state_q == S_ALUWB || state_q == S_ADDIWB;
  assign alu_src_a     = state_q == S_MEMADR || state_q == S_EXEC || state_q == S_ADDIEX || state_q == S_BRANCH;
  assign alu_src_b     = state_q == S_FETCH ? SRCB_4 :
                         state_q == S_DECODE ? SRCB_BOFF :
                         (state_q == S_MEMADR || state_q == S_ADDIEX) ? SRCB_IMM : SRCB_RT;
  assign alu_op        = state_q == S_EXEC ? ALU_FUNCT : state_q == S_BRANCH ? ALU_SUB : ALU_ADD;
  assign pc_source     = state_q == S_BRANCH ? PCS_ALUOUT : state_q == S_JUMP ? PCS_JUMP : PCS_ALU;
  assign illegal_op    = illegal_q;
  multicycle_control_fsm_retire_counter #(.CNT_W(CNT_W)) u_retire (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fin),
    .count (retired)
  );
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: per-cycle scoreboard of expected control words for two
// instances (32-bit and 4-bit retire counters) sharing the same stimulus.
module tb_multicycle_control_fsm;
  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, G = 6'b111111;
  // {pcw, pwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca, srcb[2], aluop[2], pcsrc[2]}
  localparam logic [15:0] C_IDLE = 16'h0000, C_FW = 16'h1010, C_FR = 16'h9410, C_DEC = 16'h0030;
  localparam logic [15:0] C_MADR = 16'h0060, C_MRD = 16'h3000, C_MWB = 16'h0280, C_MWR = 16'h2800;
  localparam logic [15:0] C_EXEC = 16'h0048, C_ALUWB = 16'h0180, C_ADDIEX = 16'h0060, C_ADDIWB = 16'h0080;
  localparam logic [15:0] C_BR = 16'h4045, C_J = 16'h8002;
  typedef struct {
    logic        run;
    logic        rdy;
    logic [5:0]  op;
    logic [15:0] ctrl;
    logic        fin;
    logic        ill;
    string       tag;
  } item_t;
  logic clk = 1'b0, rst_n, run, mem_ready;
  logic [5:0] opcode;
  logic [15:0] c, c4;
  logic ill, ill4;
  logic [31:0] retired, model_ret;
  logic [3:0] ret4;
  item_t q[$];
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(c[15]), .pc_write_cond(c[14]), .i_or_d(c[13]), .mem_read(c[12]),
    .mem_write(c[11]), .ir_write(c[10]), .mem_to_reg(c[9]), .reg_dst(c[8]),
    .reg_write(c[7]), .alu_src_a(c[6]), .alu_src_b(c[5:4]), .alu_op(c[3:2]),
    .pc_source(c[1:0]), .illegal_op(ill), .retired(retired)
  );
  multicycle_control_fsm #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(c4[15]), .pc_write_cond(c4[14]), .i_or_d(c4[13]), .mem_read(c4[12]),
    .mem_write(c4[11]), .ir_write(c4[10]), .mem_to_reg(c4[9]), .reg_dst(c4[8]),
    .reg_write(c4[7]), .alu_src_a(c4[6]), .alu_src_b(c4[5:4]), .alu_op(c4[3:2]),
    .pc_source(c4[1:0]), .illegal_op(ill4), .retired(ret4)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic p(input logic r, input logic rdy, input logic [5:0] op, input logic [15:0] ctrl,
                   input logic fin, input logic il, input string tag);
    item_t it;
    it.run = r; it.rdy = rdy; it.op = op; it.ctrl = ctrl; it.fin = fin; it.ill = il; it.tag = tag;
    q.push_back(it);
  endtask
  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction
  task automatic idle(input logic r);
    p(r, rnd(), G, C_IDLE, 0, 0, "idle");
  endtask
  task automatic instr(input logic [5:0] op, input int fw, input int mw, input logic run_end,
                       input logic abort = 1'b0);
    for (int i = 0; i < fw; i++) p(1, 0, op, C_FW, 0, 0, "fetch_wait");
    p(1, 1, op, C_FR, 0, 0, "fetch");
    p(1, rnd(), op, C_DEC, 0, 0, "decode");
    if (op == R) begin
      p(1, rnd(), G, C_EXEC, 0, 0, "exec");
      p(run_end, rnd(), G, C_ALUWB, 1, 0, "aluwb");
    end else if (op == LW) begin
      p(1, rnd(), G, C_MADR, 0, 0, "memadr_lw");
      for (int i = 0; i < mw; i++) p(1, 0, G, C_MRD, 0, 0, "memrd_wait");
      p(1, 1, G, C_MRD, 0, 0, "memrd");
      p(run_end, rnd(), G, C_MWB, 1, 0, "memwb");
    end else if (op == SW) begin
      p(1, rnd(), G, C_MADR, 0, 0, "memadr_sw");
      for (int i = 0; i < mw; i++) p(1, 0, G, C_MWR, 0, 0, "memwr_wait");
      if (!abort) p(run_end, 1, G, C_MWR, 1, 0, "memwr");
    end else if (op == BEQ) begin
      p(run_end, rnd(), G, C_BR, 1, 0, "branch");
    end else if (op == ADDI) begin
      p(1, rnd(), G, C_ADDIEX, 0, 0, "addiex");
      p(run_end, rnd(), G, C_ADDIWB, 1, 0, "addiwb");
    end else if (op == J) begin
      p(run_end, rnd(), G, C_J, 1, 0, "jump");
    end else begin
      for (int i = 0; i < 3; i++) p(1, rnd(), G, C_IDLE, 0, 1, "error");
    end
  endtask
  task automatic drain();
    item_t it;
    while (q.size() > 0) begin
      it = q.pop_front();
      @(negedge clk);
      run = it.run; mem_ready = it.rdy; opcode = it.op;
      #1;
      chk({it.tag, ".ctrl"}, 32'(c), 32'(it.ctrl));
      chk({it.tag, ".ctrl4"}, 32'(c4), 32'(it.ctrl));
      chk({it.tag, ".ill"}, 32'(ill), 32'(it.ill));
      chk({it.tag, ".ret"}, retired, model_ret);
      chk({it.tag, ".ret4"}, 32'(ret4), 32'(model_ret[3:0]));
      if (it.fin) model_ret++;
    end
  endtask
  task automatic check_reset(input string tag);
    chk({tag, ".ctrl"}, 32'(c), 0);
    chk({tag, ".ctrl4"}, 32'(c4), 0);
    chk({tag, ".ill"}, 32'({ill, ill4}), 0);
    chk({tag, ".ret"}, retired, 0);
    chk({tag, ".ret4"}, 32'(ret4), 0);
  endtask
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    run = 1'b0;
    #1 check_reset(tag);
    @(negedge clk);
    rst_n = 1'b1;
    model_ret = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; opcode = R; model_ret = 0;
    repeat (2) @(negedge clk);
    #1 check_reset("reset");
    rst_n = 1'b1;
    idle(1);
    instr(R, 0, 0, 1);
    instr(LW, 0, 2, 1);
    instr(SW, 0, 0, 1);
    instr(BEQ, 0, 0, 1);
    instr(ADDI, 1, 0, 1);
    instr(J, 2, 0, 0);
    idle(0); idle(0);
    idle(1);
    repeat (16) instr(J, 0, 0, 1);
    instr(G, 0, 0, 1);
    drain();
    do_reset("reset_from_error");
    idle(1);
    instr(SW, 0, 2, 1, 1'b1);
    drain();
    do_reset("reset_in_memwr");
    idle(1);
    instr(R, 0, 0, 0);
    idle(0); idle(0); idle(0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
